// File: rtl/sel_encode_pkg.sv
// sel_encode_pkg: shared defaults, field-select enum and field-offset helpers
// for the register select/encode unit.
package sel_encode_pkg;

    localparam int DEF_NUM_REGS  = 16;
    localparam int DEF_INSTR_W   = 32;
    localparam int DEF_OPCODE_W  = 5;
    localparam int DEF_REG_IDX_W = $clog2(DEF_NUM_REGS);

    typedef enum logic [1:0] {SEL_NONE, SEL_RA, SEL_RB, SEL_RC} sel_field_t;

    // Register fields sit directly below the opcode, ra first, then rb, then rc.
    function automatic int ra_lo(input int instr_w, input int opcode_w, input int idx_w);
        return instr_w - opcode_w - idx_w;
    endfunction

    function automatic int rb_lo(input int instr_w, input int opcode_w, input int idx_w);
        return instr_w - opcode_w - 2 * idx_w;
    endfunction

    function automatic int rc_lo(input int instr_w, input int opcode_w, input int idx_w);
        return instr_w - opcode_w - 3 * idx_w;
    endfunction

endpackage

// File: rtl/sel_encode_seq_onehot_decoder.sv
// onehot_decoder: binary index to one-hot vector, gated by an enable.
module onehot_decoder #(
    parameter int IDX_W = 4,
    localparam int N = 1 << IDX_W
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N-1:0]     onehot
);

    assign onehot = en ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/sel_encode_seq.sv
// sel_encode_seq: IR latch, ra/rb/rc select-encode with R0 base-zero, write-pending
// scoreboard with hazard flag, sticky select error. Optional c1_sext via SEL_ENCODE_C1_EN.
module sel_encode_seq
    import sel_encode_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int REG_IDX_W = $clog2(NUM_REGS),
    parameter int INSTR_W   = DEF_INSTR_W,
    parameter int OPCODE_W  = DEF_OPCODE_W,
    parameter int C2_W      = 19
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ir_load,
    input  logic [INSTR_W-1:0]  instr_in,
    input  logic                Gra,
    input  logic                Grb,
    input  logic                Grc,
    input  logic                Rin,
    input  logic                Rout,
    input  logic                BAout,
    input  logic                reserve,
    input  logic                flush,
    output logic [OPCODE_W-1:0] opcode,
    output logic [NUM_REGS-1:0] r_in,
    output logic [NUM_REGS-1:0] r_out,
    output logic                base_zero,
    output logic [INSTR_W-1:0]  c2_sext,
`ifdef SEL_ENCODE_C1_EN
    output logic [INSTR_W-1:0]  c1_sext,
`endif
    output logic                ir_valid,
    output logic [NUM_REGS-1:0] pending,
    output logic                hazard,
    output logic                sel_err
);

    localparam int RA_LO = ra_lo(INSTR_W, OPCODE_W, REG_IDX_W);
    localparam int RB_LO = rb_lo(INSTR_W, OPCODE_W, REG_IDX_W);
    localparam int RC_LO = rc_lo(INSTR_W, OPCODE_W, REG_IDX_W);

    logic [INSTR_W-1:0]   ir;
    logic [REG_IDX_W-1:0] ra, rb, rc, idx;
    logic [NUM_REGS-1:0]  pend_next;
    sel_field_t           sel;
    logic                 hit, multi;

    assign ra      = ir[RA_LO +: REG_IDX_W];
    assign rb      = ir[RB_LO +: REG_IDX_W];
    assign rc      = ir[RC_LO +: REG_IDX_W];
    assign opcode  = ir[INSTR_W-1 -: OPCODE_W];
    assign c2_sext = {{(INSTR_W-C2_W){ir[C2_W-1]}}, ir[C2_W-1:0]};

`ifdef SEL_ENCODE_C1_EN
    localparam int C1_W = INSTR_W - OPCODE_W - REG_IDX_W;
    assign c1_sext = {{(INSTR_W-C1_W){ir[C1_W-1]}}, ir[C1_W-1:0]};
`endif

    always_comb begin
        sel = Gra ? SEL_RA : Grb ? SEL_RB : Grc ? SEL_RC : SEL_NONE;
        idx = (sel == SEL_RB) ? rb : (sel == SEL_RC) ? rc : ra;
    end

    assign hit       = sel != SEL_NONE;
    assign multi     = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
    // A pure base-address read of R0 means "no base": drive zero instead of R0.
    assign base_zero = hit & BAout & ~Rout & (idx == '0);
    assign hazard    = ir_valid & (pending[rb] | pending[rc]);

    onehot_decoder #(.IDX_W(REG_IDX_W)) u_in_dec (
        .idx    (idx),
        .en     (hit & Rin),
        .onehot (r_in)
    );

    onehot_decoder #(.IDX_W(REG_IDX_W)) u_out_dec (
        .idx    (idx),
        .en     (hit & (Rout | BAout) & ~base_zero),
        .onehot (r_out)
    );

    // Ordering gives flush < write-back clear < reserve set.
    always_comb begin
        pend_next = (flush ? '0 : pending) & ~r_in;
        if (reserve && ir_valid) pend_next[ra] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir       <= '0;
            ir_valid <= 1'b0;
            pending  <= '0;
            sel_err  <= 1'b0;
        end else begin
            if (ir_load) begin
                ir       <= instr_in;
                ir_valid <= 1'b1;
            end
            pending <= pend_next;
            if (multi) sel_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sel_encode_seq.sv
// tb_sel_encode_seq: directed + random stimulus, expected outputs queued by a
// reference model and compared by an independent negedge monitor.
module tb_sel_encode_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ir_load = 1'b0;
    logic [31:0] instr_in = '0;
    logic        Gra = 1'b0, Grb = 1'b0, Grc = 1'b0;
    logic        Rin = 1'b0, Rout = 1'b0, BAout = 1'b0;
    logic        reserve = 1'b0, flush = 1'b0;
    logic [4:0]  opcode;
    logic [15:0] r_in, r_out, pending;
    logic        base_zero, ir_valid, hazard, sel_err;
    logic [31:0] c2_sext;
`ifdef SEL_ENCODE_C1_EN
    logic [31:0] c1_sext;
`endif

    sel_encode_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir_load   (ir_load),
        .instr_in  (instr_in),
        .Gra       (Gra),
        .Grb       (Grb),
        .Grc       (Grc),
        .Rin       (Rin),
        .Rout      (Rout),
        .BAout     (BAout),
        .reserve   (reserve),
        .flush     (flush),
        .opcode    (opcode),
        .r_in      (r_in),
        .r_out     (r_out),
        .base_zero (base_zero),
        .c2_sext   (c2_sext),
`ifdef SEL_ENCODE_C1_EN
        .c1_sext   (c1_sext),
`endif
        .ir_valid  (ir_valid),
        .pending   (pending),
        .hazard    (hazard),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  opcode;
        logic [15:0] r_in, r_out, pend;
        logic        bz, iv, hz, se;
        logic [31:0] c2;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // Reference model state (value held after the most recent edge).
    logic [31:0] m_ir;
    logic        m_valid, m_err;
    logic [15:0] m_pend;

    function automatic int fld(input logic [31:0] w, input int lo);
        return int'((w >> lo) & 32'hF);
    endfunction

    task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, c, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("opcode",    e.cyc, 32'(opcode),    32'(e.opcode));
            chk("r_in",      e.cyc, 32'(r_in),      32'(e.r_in));
            chk("r_out",     e.cyc, 32'(r_out),     32'(e.r_out));
            chk("base_zero", e.cyc, 32'(base_zero), 32'(e.bz));
            chk("c2_sext",   e.cyc, c2_sext,        e.c2);
            chk("ir_valid",  e.cyc, 32'(ir_valid),  32'(e.iv));
            chk("pending",   e.cyc, 32'(pending),   32'(e.pend));
            chk("hazard",    e.cyc, 32'(hazard),    32'(e.hz));
            chk("sel_err",   e.cyc, 32'(sel_err),   32'(e.se));
        end
    end

    function automatic exp_t expect_now(input logic ga, gb, gc, rin, rout, ba);
        exp_t e;
        int   ra, rb, rc, idx, c2;
        bit   sel;
        ra  = fld(m_ir, 23);
        rb  = fld(m_ir, 19);
        rc  = fld(m_ir, 15);
        sel = ga || gb || gc;
        idx = ga ? ra : gb ? rb : rc;
        e.opcode = 5'(m_ir / (1 << 27));
        e.bz     = sel && ba && !rout && idx == 0;
        e.r_in   = (sel && rin) ? 16'(1 << idx) : 16'h0;
        e.r_out  = (sel && (rout || ba) && !e.bz) ? 16'(1 << idx) : 16'h0;
        c2 = int'(m_ir & 32'h7FFFF);
        if (c2 >= 'h40000) c2 = c2 - 'h80000;
        e.c2   = 32'(c2);
        e.iv   = m_valid;
        e.pend = m_pend;
        e.hz   = m_valid && (m_pend[rb] || m_pend[rc]);
        e.se   = m_err;
        e.cyc  = cyc;
        return e;
    endfunction

    task automatic model_reset();
        m_ir = '0;
        m_valid = 1'b0;
        m_err = 1'b0;
        m_pend = '0;
    endtask

    task automatic drive(input logic ld, input logic [31:0] ins, input logic ga, gb, gc,
                         input logic rin, rout, ba, res, fl);
        exp_t e;
        int   ra, idx;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        ir_load = ld; instr_in = ins;
        Gra = ga; Grb = gb; Grc = gc;
        Rin = rin; Rout = rout; BAout = ba;
        reserve = res; flush = fl;
        e = expect_now(ga, gb, gc, rin, rout, ba);
        exp_q.push_back(e);
        ra  = fld(m_ir, 23);
        idx = ga ? ra : gb ? fld(m_ir, 19) : fld(m_ir, 15);
        if (fl) m_pend = '0;
        if ((ga || gb || gc) && rin) m_pend[idx] = 1'b0;
        if (res && m_valid) m_pend[ra] = 1'b1;
        if (int'(ga) + int'(gb) + int'(gc) >= 2) m_err = 1'b1;
        if (ld) begin
            m_ir = ins;
            m_valid = 1'b1;
        end
    endtask

    task automatic idle();
        drive(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input logic [31:0] ins);
        drive(1, ins, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asserted just after an edge; the monitor samples before the next edge.
    task automatic async_reset();
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b0;
        {ir_load, Gra, Grb, Grc, Rin, Rout, BAout, reserve, flush} = '0;
        model_reset();
        exp_q.push_back(expect_now(0, 0, 0, 0, 0, 0));
    endtask

    function automatic logic [31:0] mk(input int op, ra, rb, rc);
        return 32'((op << 27) | (ra << 23) | (rb << 19) | (rc << 15));
    endfunction

    initial begin
        model_reset();
        async_reset();
        idle();
        load(32'h0898_0000);
        drive(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        load(mk(1, 0, 3, 0));
        drive(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        load(mk(1, 5, 3, 0));
        drive(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        load(32'h0004_0000);
        load(32'h0003_FFFF);
        idle();
        load(mk(2, 3, 0, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        load(mk(3, 1, 3, 2));
        idle();
        load(mk(4, 3, 0, 0));
        drive(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        idle();
        load(mk(0, 7, 1, 2));
        drive(0, 0, 1, 0, 0, 1, 0, 0, 1, 0);
        idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, mk(5, 9, 7, 0), 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        async_reset();
        idle();
        load(mk(1, 2, 6, 4));
        drive(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        idle();
        drive(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        async_reset();
        idle();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) async_reset();
            else drive($urandom_range(0, 3) == 0, $urandom,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain got=%0d pending entries want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
